bcd_seq_state_fsm: RTL and testbench
====================================

Name: bcd_seq_state_fsm

Overview:
- Next-state logic and state register for the BCD-digit Mealy sequence detector.
- Feeds the detector's output-decode stage, which asserts its match output combinationally when the current state is S3 and the presented digit is 9.
- Tracks progress through the 4-digit sequence D0,D1,D2,9 over a digit stream with gaps.
- Gates invalid cycles so the output stage never sees a false 9, aborts stalled partial matches, and counts completed detections.

Parameters:
- D0, 4'd2, first sequence digit (legal 0..9)
- D1, 4'd0, second sequence digit (legal 0..9)
- D2, 4'd1, third sequence digit (legal 0..9)
- TIMEOUT, 16, consecutive idle cycles in a non-S0 state before abort (legal 2..255)
- CNT_W, 8, width of the detection counter

Ports:
- clk_i  input  1  clock; all state changes on the rising edge
- rst_i  input  1  synchronous, active-high reset
- data_i  input  4  BCD digit from the digit source
- data_valid_i  input  1  data_i carries a new digit this cycle
- CurrentState_o  output  2  registered state (S0=00, S1=01, S2=10, S3=11), to the output stage's CurrentState_i
- data_o  output  4  gated digit, to the output stage's data_i
- match_count_o  output  CNT_W  saturating count of completed detections
- timeout_o  output  1  one-cycle pulse: a partial match was aborted by timeout

Behaviour:
- Interface: one clock, clk_i. rst_i is synchronous and active-high.
- Reset: while rst_i=1 at an edge, the next values are:
  - CurrentState_o=S0
  - match_count_o=0
  - timeout_o=0
  - idle counter=0
- Reset overrides all other events, including mid-sequence.
- data_o is combinational:
  - data_valid_i=1 → data_o=data_i
  - data_valid_i=0 → data_o=4'd15
- Consequence: the downstream 9-decode only fires on valid cycles.
- State transitions on a valid digit d. Let fb = (d==D0) ? S1 : S0.
  - S0: d==D0 → S1, else S0.
  - S1: d==D1 → S2, else fb.
  - S2: d==D2 → S3, else fb.
  - S3: d==9 → detection, next state fb. Otherwise next state fb.
  - Any d in 10..15 → S0, from any state.
- data_valid_i=0: the state holds, unless the timeout below fires.
- Detection:
  - A detection is a valid cycle with state S3 and d==9. It is the same cycle the output stage asserts its match.
  - match_count_o increments by 1 at that edge and saturates at 2^CNT_W-1.
- Idle counter and timeout:
  - The idle counter clears on any valid cycle and whenever the state is S0.
  - Otherwise it increments on each idle cycle.
  - On an idle cycle with the counter at TIMEOUT-1:
    - next state = S0
    - idle counter = 0
    - timeout_o = 1 for the following cycle only
  - So the abort lands on the edge ending the TIMEOUT-th consecutive idle cycle.
  - A valid digit always beats the timeout; there is never a timeout on a valid cycle.
- timeout_o is registered and is 0 in all other cycles.
- Latency:
  - State update is 1 cycle after the digit.
  - Count update is 1 cycle after the detection.
  - data_o has 0 cycles of latency.
- No backpressure: every valid digit is consumed in its cycle.

Test Plan:
1. Reset: hold rst_i=1 for 2 cycles from random state → CurrentState_o=00, match_count_o=0, timeout_o=0. Assert rst_i while in S2 → S0 on the next edge.
2. Back-to-back stream 2,0,1,9 (valid every cycle):
   - State after each edge is 01, 10, 11, 00.
   - In the 9 cycle: state=11 and data_o=9.
   - After that edge, match_count_o=1.
3. Gapped stream 2,-,-,-,0,1,-,9 (- = invalid cycle):
   - data_o=15 on each gap.
   - State holds across the gaps.
   - Detection in the 9 cycle; count=1.
4. Fallback 2,0,2,0,1,9:
   - State after the third digit is 01, then 10, 11.
   - Exactly one detection.
   - Stream 2,0,1,5 → state 00, no count change.
5. Timeout: 2,0 then 16 idle cycles.
   - State 10 through the 15th idle edge; 00 after the 16th.
   - timeout_o=1 for exactly one cycle.
   - Then 1,9 → no detection.
   - Repeat with a valid digit on idle cycle 16 → no timeout.
6. Non-BCD and saturation:
   - 2,0,12 → state 00.
   - 255 detections then one more → match_count_o stays 255.

Source files
------------

// File: rtl/bcd_seq_state_fsm.sv
// ============================================================================
// Module      : bcd_seq_state_fsm
// Description : State register and next-state logic for the D0,D1,D2,9 BCD
//               sequence detector, with invalid-cycle gating, idle timeout
//               and a saturating detection counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_seq_state_fsm #(
    parameter logic [3:0] D0      = 4'd2,
    parameter logic [3:0] D1      = 4'd0,
    parameter logic [3:0] D2      = 4'd1,
    parameter int         TIMEOUT = 16,
    parameter int         CNT_W   = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [3:0]       data_i,
    input  logic             data_valid_i,
    output logic [1:0]       CurrentState_o,
    output logic [3:0]       data_o,
    output logic [CNT_W-1:0] match_count_o,
    output logic             timeout_o
);

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } state_t;

    localparam int               IDLE_W     = 8;
    localparam logic [IDLE_W-1:0] C_IDLE_LAST = IDLE_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  C_CNT_MAX   = '1;
    localparam logic [3:0]        C_NINE      = 4'd9;
    localparam logic [3:0]        C_GAP_DIGIT = 4'd15;

    state_t              state_q, state_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                timeout_q, timeout_d;

    state_t              w_fallback;
    logic                w_detect;

    // Gap cycles present 15, which the downstream 9-decode can never match.
    assign data_o         = data_valid_i ? data_i : C_GAP_DIGIT;
    assign CurrentState_o = state_q;
    assign match_count_o  = count_q;
    assign timeout_o      = timeout_q;

    assign w_fallback = (data_i == D0) ? S1 : S0;
    assign w_detect   = data_valid_i && (state_q == S3) && (data_i == C_NINE);

    always_comb begin
        state_d   = state_q;
        idle_d    = idle_q;
        count_d   = count_q;
        timeout_d = 1'b0;

        if (data_valid_i) begin
            idle_d = '0;
            if (data_i > C_NINE) begin
                state_d = S0;
            end else begin
                case (state_q)
                    S0:      state_d = (data_i == D0) ? S1 : S0;
                    S1:      state_d = (data_i == D1) ? S2 : w_fallback;
                    S2:      state_d = (data_i == D2) ? S3 : w_fallback;
                    default: state_d = w_fallback;
                endcase
            end
        end else if (state_q == S0) begin
            idle_d = '0;
        end else if (idle_q == C_IDLE_LAST) begin
            state_d   = S0;
            idle_d    = '0;
            timeout_d = 1'b1;
        end else begin
            idle_d = idle_q + 1'b1;
        end

        if (w_detect && (count_q != C_CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S0;
            idle_q    <= '0;
            count_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idle_q    <= idle_d;
            count_q   <= count_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bcd_seq_state_fsm.sv
// ============================================================================
// Module      : tb_bcd_seq_state_fsm
// Description : Directed-vector scoreboard bench for bcd_seq_state_fsm.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_seq_state_fsm;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [3:0] data_i;
    logic       data_valid_i;
    logic [1:0] state_o;
    logic [3:0] data_o;
    logic [7:0] count_o;
    logic       timeout_o;

    typedef struct {
        logic [3:0] dout;
        logic [1:0] st;
        logic [7:0] cnt;
        logic       to;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    bcd_seq_state_fsm #(
        .D0(4'd2), .D1(4'd0), .D2(4'd1), .TIMEOUT(16), .CNT_W(8)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .data_i         (data_i),
        .data_valid_i   (data_valid_i),
        .CurrentState_o (state_o),
        .data_o         (data_o),
        .match_count_o  (count_o),
        .timeout_o      (timeout_o)
    );

    always #5 clk = ~clk;

    // Drive one cycle and queue the expected data_o for it plus the
    // registered outputs expected after its closing edge.
    task automatic step(input logic r, input logic v, input logic [3:0] d,
                        input logic [1:0] es, input logic [7:0] ec, input logic et);
        exp_t e;
        @(posedge clk);
        #1;
        rst_i        = r;
        data_valid_i = v;
        data_i       = d;
        e.dout = v ? d : 4'd15;
        e.st   = es;
        e.cnt  = ec;
        e.to   = et;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 4'd0, 2'd0, 8'd0, 1'b0);
    endtask

    // Monitor: data_o mid-cycle, registered outputs just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (data_o !== e.dout) begin
                    n_err++;
                    $display("FAIL data_o vec %0d: got %0d expected %0d", n_vec, data_o, e.dout);
                end
                @(posedge clk);
                #2;
                if (state_o !== e.st) begin
                    n_err++;
                    $display("FAIL state vec %0d: got %b expected %b", n_vec, state_o, e.st);
                end
                if (count_o !== e.cnt) begin
                    n_err++;
                    $display("FAIL count vec %0d: got %0d expected %0d", n_vec, count_o, e.cnt);
                end
                if (timeout_o !== e.to) begin
                    n_err++;
                    $display("FAIL timeout vec %0d: got %b expected %b", n_vec, timeout_o, e.to);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        rst_i        = 1'b1;
        data_valid_i = 1'b0;
        data_i       = 4'd0;
        repeat (2) @(posedge clk);

        // Reset from arbitrary state, and reset overriding a live sequence in S2
        do_reset();
        do_reset();
        step(0, 1, 4'd2, 2'd1, 8'd0, 0);
        step(0, 1, 4'd0, 2'd2, 8'd0, 0);
        step(1, 1, 4'd1, 2'd0, 8'd0, 0);
        do_reset();

        // Back-to-back 2,0,1,9
        step(0, 1, 4'd2, 2'd1, 8'd0, 0);
        step(0, 1, 4'd0, 2'd2, 8'd0, 0);
        step(0, 1, 4'd1, 2'd3, 8'd0, 0);
        step(0, 1, 4'd9, 2'd0, 8'd1, 0);

        // Gapped 2,-,-,-,0,1,-,9
        do_reset();
        step(0, 1, 4'd2, 2'd1, 8'd0, 0);
        step(0, 0, 4'd9, 2'd1, 8'd0, 0);
        step(0, 0, 4'd9, 2'd1, 8'd0, 0);
        step(0, 0, 4'd3, 2'd1, 8'd0, 0);
        step(0, 1, 4'd0, 2'd2, 8'd0, 0);
        step(0, 1, 4'd1, 2'd3, 8'd0, 0);
        step(0, 0, 4'd9, 2'd3, 8'd0, 0);
        step(0, 1, 4'd9, 2'd0, 8'd1, 0);

        // Fallback 2,0,2,0,1,9 then 2,0,1,5
        do_reset();
        step(0, 1, 4'd2, 2'd1, 8'd0, 0);
        step(0, 1, 4'd0, 2'd2, 8'd0, 0);
        step(0, 1, 4'd2, 2'd1, 8'd0, 0);
        step(0, 1, 4'd0, 2'd2, 8'd0, 0);
        step(0, 1, 4'd1, 2'd3, 8'd0, 0);
        step(0, 1, 4'd9, 2'd0, 8'd1, 0);
        step(0, 1, 4'd2, 2'd1, 8'd1, 0);
        step(0, 1, 4'd0, 2'd2, 8'd1, 0);
        step(0, 1, 4'd1, 2'd3, 8'd1, 0);
        step(0, 1, 4'd5, 2'd0, 8'd1, 0);
        // Non-D0 digits in S1/S3 fall to S0, D0 in S3 restarts at S1
        step(0, 1, 4'd2, 2'd1, 8'd1, 0);
        step(0, 1, 4'd7, 2'd0, 8'd1, 0);
        step(0, 1, 4'd2, 2'd1, 8'd1, 0);
        step(0, 1, 4'd0, 2'd2, 8'd1, 0);
        step(0, 1, 4'd1, 2'd3, 8'd1, 0);
        step(0, 1, 4'd2, 2'd1, 8'd1, 0);

        // Timeout: 2,0 then 16 idle cycles, then 1,9 gives no detection
        do_reset();
        step(0, 1, 4'd2, 2'd1, 8'd0, 0);
        step(0, 1, 4'd0, 2'd2, 8'd0, 0);
        for (int i = 1; i <= 15; i++) step(0, 0, 4'd9, 2'd2, 8'd0, 0);
        step(0, 0, 4'd9, 2'd0, 8'd0, 1);
        step(0, 1, 4'd1, 2'd0, 8'd0, 0);
        step(0, 1, 4'd9, 2'd0, 8'd0, 0);
        // Long idle in S0 never times out
        for (int i = 1; i <= 20; i++) step(0, 0, 4'd0, 2'd0, 8'd0, 0);
        // Valid digit on idle cycle 16 beats the timeout
        step(0, 1, 4'd2, 2'd1, 8'd0, 0);
        step(0, 1, 4'd0, 2'd2, 8'd0, 0);
        for (int i = 1; i <= 15; i++) step(0, 0, 4'd0, 2'd2, 8'd0, 0);
        step(0, 1, 4'd1, 2'd3, 8'd0, 0);
        step(0, 1, 4'd9, 2'd0, 8'd1, 0);
        // A valid digit mid-gap restarts the idle count
        step(0, 1, 4'd2, 2'd1, 8'd1, 0);
        for (int i = 1; i <= 10; i++) step(0, 0, 4'd0, 2'd1, 8'd1, 0);
        step(0, 1, 4'd0, 2'd2, 8'd1, 0);
        for (int i = 1; i <= 15; i++) step(0, 0, 4'd0, 2'd2, 8'd1, 0);
        step(0, 0, 4'd0, 2'd0, 8'd1, 1);
        step(0, 0, 4'd0, 2'd0, 8'd1, 0);

        // Non-BCD digits abort from any state
        do_reset();
        step(0, 1, 4'd2,  2'd1, 8'd0, 0);
        step(0, 1, 4'd0,  2'd2, 8'd0, 0);
        step(0, 1, 4'd12, 2'd0, 8'd0, 0);
        step(0, 1, 4'd2,  2'd1, 8'd0, 0);
        step(0, 1, 4'd0,  2'd2, 8'd0, 0);
        step(0, 1, 4'd1,  2'd3, 8'd0, 0);
        step(0, 1, 4'd15, 2'd0, 8'd0, 0);

        // Saturation: 256 detections leave the count at 255
        do_reset();
        for (int k = 1; k <= 256; k++) begin
            step(0, 1, 4'd2, 2'd1, 8'((k - 1) > 255 ? 255 : (k - 1)), 0);
            step(0, 1, 4'd0, 2'd2, 8'((k - 1) > 255 ? 255 : (k - 1)), 0);
            step(0, 1, 4'd1, 2'd3, 8'((k - 1) > 255 ? 255 : (k - 1)), 0);
            step(0, 1, 4'd9, 2'd0, 8'(k > 255 ? 255 : k), 0);
        end

        repeat (4) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
